riscv_core_reorder_buffer: RTL and testbench

- In-order-commit reorder buffer downstream of the 5-stage/X2/X3 datapath writeback.
- Decode allocates a tagged slot per issued instruction. ALU/memory and pipelined mul/div results fill slots out of order.
- The buffer retires the oldest completed entry each cycle to the register file.
- Decode-side lookup ports report pending destinations and forward completed-but-uncommitted data.

---
 rtl/riscv_core_reorder_buffer_pkg.sv | 13 +
 rtl/riscv_core_rob_lookup.sv | 50 +++++
 rtl/riscv_core_reorder_buffer.sv | 131 +++++++++++++
 tb/tb_riscv_core_reorder_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_reorder_buffer_pkg.sv
// rtl/riscv_core_reorder_buffer_pkg.sv - shared sizes and constants for the reorder buffer
// Provides the default slot count and tag width, register-address and data widths,
// and the x0 register constant used to suppress writes and lookups.
package riscv_core_reorder_buffer_pkg;

  localparam int ROB_ENTRIES = 16;
  localparam int ROB_TAG_W   = 4;
  localparam int REG_ADDR_W  = 5;
  localparam int XLEN        = 32;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/riscv_core_rob_lookup.sv
// rtl/riscv_core_rob_lookup.sv - youngest-producer search for one decode source register
// Walks the slots in age order starting at head; the last match seen is the youngest.
// Ports:
//   valid, wen, waddr    per-slot state vectors
//   done, data           per-slot completion and result (present only with ROB_BYPASS_EN)
//   head                 oldest slot index
//   src_addr             source register being looked up
//   pending              some uncommitted slot will write src_addr
//   ready, src_data      youngest producer's done flag and result (0 without ROB_BYPASS_EN)
module riscv_core_rob_lookup
  import riscv_core_reorder_buffer_pkg::*;
#(
  parameter int ENTRIES = ROB_ENTRIES,
  parameter int TAG_W   = ROB_TAG_W
) (
  input  logic [ENTRIES-1:0]                 valid,
  input  logic [ENTRIES-1:0]                 wen,
`ifdef ROB_BYPASS_EN
  input  logic [ENTRIES-1:0]                 done,
  input  logic [ENTRIES-1:0][XLEN-1:0]       data,
`endif
  input  logic [ENTRIES-1:0][REG_ADDR_W-1:0] waddr,
  input  logic [TAG_W-1:0]                   head,
  input  logic [REG_ADDR_W-1:0]              src_addr,
  output logic                               pending,
  output logic                               ready,
  output logic [XLEN-1:0]                    src_data
);

  logic [TAG_W-1:0] idx;

  always_comb begin
    pending  = 1'b0;
    ready    = 1'b0;
    src_data = '0;
    idx      = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      idx = head + TAG_W'(i);
      // Later iterations are younger, so they overwrite older matches.
      if (valid[idx] && wen[idx] && (waddr[idx] == src_addr) && (src_addr != REG_X0)) begin
        pending = 1'b1;
`ifdef ROB_BYPASS_EN
        ready    = done[idx];
        src_data = data[idx];
`endif
      end
    end
  end

endmodule

// File: rtl/riscv_core_reorder_buffer.sv
// rtl/riscv_core_reorder_buffer.sv - in-order-commit reorder buffer with out-of-order fills
// Optional macro ROB_BYPASS_EN: forwards completed-but-uncommitted results to decode;
// without it srcN_ready/srcN_data are tied to 0 and decode stalls on pending.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   alloc_val/rdy/wen/waddr/tag      decode allocation at the tail
//   fill0_*, fill1_*                 ALU/mem and mul/div result writes by tag
//   commit_val/wen/waddr/data        head retirement to the register file
//   src0_*, src1_*                   decode-side pending/ready/data lookups
module riscv_core_reorder_buffer
  import riscv_core_reorder_buffer_pkg::*;
#(
  parameter int ENTRIES = ROB_ENTRIES,
  parameter int TAG_W   = ROB_TAG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_val,
  output logic                  alloc_rdy,
  input  logic                  alloc_wen,
  input  logic [REG_ADDR_W-1:0] alloc_waddr,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic                  fill0_val,
  input  logic [TAG_W-1:0]      fill0_tag,
  input  logic [XLEN-1:0]       fill0_data,
  input  logic                  fill1_val,
  input  logic [TAG_W-1:0]      fill1_tag,
  input  logic [XLEN-1:0]       fill1_data,
  output logic                  commit_val,
  output logic                  commit_wen,
  output logic [REG_ADDR_W-1:0] commit_waddr,
  output logic [XLEN-1:0]       commit_data,
  input  logic [REG_ADDR_W-1:0] src0_addr,
  input  logic [REG_ADDR_W-1:0] src1_addr,
  output logic                  src0_pending,
  output logic                  src1_pending,
  output logic                  src0_ready,
  output logic                  src1_ready,
  output logic [XLEN-1:0]       src0_data,
  output logic [XLEN-1:0]       src1_data
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ENTRIES);

  logic [ENTRIES-1:0]                 valid;
  logic [ENTRIES-1:0]                 done;
  logic [ENTRIES-1:0]                 wen;
  logic [ENTRIES-1:0][REG_ADDR_W-1:0] waddr;
  logic [ENTRIES-1:0][XLEN-1:0]       data;
  logic [TAG_W-1:0]                   head;
  logic [TAG_W-1:0]                   tail;
  logic [TAG_W:0]                     count;
  logic                               alloc_fire;

  // Ready depends on registered count only, so a same-cycle commit never frees a slot.
  assign alloc_rdy    = (count != FULL_COUNT);
  assign alloc_tag    = tail;
  assign alloc_fire   = alloc_val && alloc_rdy;

  assign commit_val   = valid[head] && done[head];
  assign commit_waddr = waddr[head];
  assign commit_data  = data[head];
  assign commit_wen   = commit_val && wen[head] && (waddr[head] != REG_X0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (commit_val) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      // Port 1 is written first so port 0 wins a same-tag collision.
      if (fill1_val && valid[fill1_tag]) begin
        data[fill1_tag] <= fill1_data;
        done[fill1_tag] <= 1'b1;
      end
      if (fill0_val && valid[fill0_tag]) begin
        data[fill0_tag] <= fill0_data;
        done[fill0_tag] <= 1'b1;
      end
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        done[tail]  <= ~alloc_wen;
        wen[tail]   <= alloc_wen;
        waddr[tail] <= alloc_waddr;
        tail        <= tail + 1'b1;
      end
      case ({alloc_fire, commit_val})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  riscv_core_rob_lookup #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_src0_lookup (
    .valid    (valid),
    .wen      (wen),
`ifdef ROB_BYPASS_EN
    .done     (done),
    .data     (data),
`endif
    .waddr    (waddr),
    .head     (head),
    .src_addr (src0_addr),
    .pending  (src0_pending),
    .ready    (src0_ready),
    .src_data (src0_data)
  );

  riscv_core_rob_lookup #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_src1_lookup (
    .valid    (valid),
    .wen      (wen),
`ifdef ROB_BYPASS_EN
    .done     (done),
    .data     (data),
`endif
    .waddr    (waddr),
    .head     (head),
    .src_addr (src1_addr),
    .pending  (src1_pending),
    .ready    (src1_ready),
    .src_data (src1_data)
  );

endmodule

// File: tb/tb_riscv_core_reorder_buffer.sv
// tb/tb_riscv_core_reorder_buffer.sv - self-checking bench for riscv_core_reorder_buffer
module tb_riscv_core_reorder_buffer;

  localparam int N = 16;
`ifdef ROB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_val, alloc_rdy, alloc_wen;
  logic [4:0]  alloc_waddr;
  logic [3:0]  alloc_tag;
  logic        fill0_val, fill1_val;
  logic [3:0]  fill0_tag, fill1_tag;
  logic [31:0] fill0_data, fill1_data;
  logic        commit_val, commit_wen;
  logic [4:0]  commit_waddr;
  logic [31:0] commit_data;
  logic [4:0]  src0_addr, src1_addr;
  logic        src0_pending, src1_pending, src0_ready, src1_ready;
  logic [31:0] src0_data, src1_data;

  always #5 clk = ~clk;

  riscv_core_reorder_buffer dut (
    .clk(clk), .reset(reset),
    .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_wen(alloc_wen),
    .alloc_waddr(alloc_waddr), .alloc_tag(alloc_tag),
    .fill0_val(fill0_val), .fill0_tag(fill0_tag), .fill0_data(fill0_data),
    .fill1_val(fill1_val), .fill1_tag(fill1_tag), .fill1_data(fill1_data),
    .commit_val(commit_val), .commit_wen(commit_wen),
    .commit_waddr(commit_waddr), .commit_data(commit_data),
    .src0_addr(src0_addr), .src1_addr(src1_addr),
    .src0_pending(src0_pending), .src1_pending(src1_pending),
    .src0_ready(src0_ready), .src1_ready(src1_ready),
    .src0_data(src0_data), .src1_data(src1_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: age-ordered queue of live tags plus per-tag attributes.
  bit          m_valid [N];
  bit          m_done  [N];
  bit          m_wen   [N];
  logic [4:0]  m_waddr [N];
  logic [31:0] m_data  [N];
  int          order[$];
  int          m_tail;

  task automatic model_lookup(input logic [4:0] a, output bit p, output bit r, output logic [31:0] d);
    p = 1'b0; r = 1'b0; d = '0;
    if (a != 5'd0) begin
      for (int k = order.size() - 1; k >= 0; k--) begin
        if (m_wen[order[k]] && m_waddr[order[k]] == a) begin
          p = 1'b1;
          r = m_done[order[k]];
          d = m_data[order[k]];
          break;
        end
      end
    end
    if (!BYPASS) begin
      r = 1'b0;
      d = '0;
    end
  endtask

  task automatic check_src(input string nm, input logic [4:0] a, input logic p_obs,
                           input logic r_obs, input logic [31:0] d_obs);
    bit p, r;
    logic [31:0] d;
    model_lookup(a, p, r, d);
    check({nm, "_pending"}, 32'(p_obs), 32'(p));
    check({nm, "_ready"}, 32'(r_obs), 32'(r));
    if (r || !BYPASS) check({nm, "_data"}, d_obs, d);
  endtask

  task automatic compare();
    bit cv;
    cv = (order.size() > 0) && m_done[order[0]];
    check("alloc_rdy", 32'(alloc_rdy), 32'(order.size() != N));
    check("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    check("commit_val", 32'(commit_val), 32'(cv));
    check("commit_wen", 32'(commit_wen),
          32'(cv && m_wen[order[0]] && m_waddr[order[0]] != 5'd0));
    if (cv) begin
      check("commit_waddr", 32'(commit_waddr), 32'(m_waddr[order[0]]));
      if (m_wen[order[0]]) check("commit_data", commit_data, m_data[order[0]]);
    end
    check_src("src0", src0_addr, src0_pending, src0_ready, src0_data);
    check_src("src1", src1_addr, src1_pending, src1_ready, src1_data);
  endtask

  task automatic model_update();
    bit cv, af, v0, v1;
    if (reset) begin
      order.delete();
      m_tail = 0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end else begin
      cv = (order.size() > 0) && m_done[order[0]];
      af = alloc_val && (order.size() != N);
      v0 = fill0_val && m_valid[fill0_tag];
      v1 = fill1_val && m_valid[fill1_tag];
      if (cv) begin
        m_valid[order[0]] = 1'b0;
        void'(order.pop_front());
      end
      if (v1) begin m_data[fill1_tag] = fill1_data; m_done[fill1_tag] = 1'b1; end
      if (v0) begin m_data[fill0_tag] = fill0_data; m_done[fill0_tag] = 1'b1; end
      if (af) begin
        m_valid[m_tail] = 1'b1;
        m_done[m_tail]  = !alloc_wen;
        m_wen[m_tail]   = alloc_wen;
        m_waddr[m_tail] = alloc_waddr;
        order.push_back(m_tail);
        m_tail = (m_tail + 1) % N;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; alloc_val = 1'b0; alloc_wen = 1'b0; alloc_waddr = '0;
    fill0_val = 1'b0; fill0_tag = '0; fill0_data = '0;
    fill1_val = 1'b0; fill1_tag = '0; fill1_data = '0;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic alloc(input bit w, input logic [4:0] a);
    idle(); alloc_val = 1'b1; alloc_wen = w; alloc_waddr = a; step(); idle();
  endtask

  task automatic fill(input int port, input int tag, input logic [31:0] d);
    idle();
    if (port == 0) begin fill0_val = 1'b1; fill0_tag = 4'(tag); fill0_data = d; end
    else begin fill1_val = 1'b1; fill1_tag = 4'(tag); fill1_data = d; end
    step(); idle();
  endtask

  initial begin
    int b;
    int cand[$];
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_done[i] = 0; m_wen[i] = 0; m_waddr[i] = '0; m_data[i] = '0;
    end
    m_tail = 0;
    src0_addr = '0; src1_addr = '0;
    do_reset();
    check("reset_alloc_rdy", 32'(alloc_rdy), 32'd1);
    check("reset_commit_val", 32'(commit_val), 32'd0);

    // Single alloc/fill/commit.
    alloc(1'b1, 5'd5);
    fill(0, 0, 32'h1234);
    check("t1_commit_val", 32'(commit_val), 32'd1);
    check("t1_commit_data", commit_data, 32'h1234);
    step();

    // Out-of-order fills, in-order commits.
    b = m_tail;
    alloc(1'b1, 5'd1); alloc(1'b1, 5'd2); alloc(1'b1, 5'd3);
    fill(1, (b + 2) % N, 32'h30);
    fill(0, b, 32'h10);
    fill(0, (b + 1) % N, 32'h20);
    repeat (4) step();

    // Full buffer, commit+alloc in the same cycle, tail wrap.
    do_reset();
    idle(); alloc_val = 1'b1; alloc_wen = 1'b1; alloc_waddr = 5'd9;
    repeat (N + 1) step();
    fill0_val = 1'b1; fill0_tag = 4'(order[0]); fill0_data = 32'h55;
    step();
    fill0_val = 1'b0;
    step();
    step();
    idle(); step();

    // Youngest producer wins; bypass visibility.
    do_reset();
    alloc(1'b1, 5'd1); alloc(1'b1, 5'd1); alloc(1'b1, 5'd1);
    alloc(1'b1, 5'd7);
    fill(0, 3, 32'hAA);
    alloc(1'b1, 5'd7);
    src0_addr = 5'd7; src1_addr = 5'd1;
    step();
    check("t4_pending", 32'(src0_pending), 32'd1);
    check("t4_ready_before", 32'(src0_ready), 32'd0);
    fill(1, 4, 32'hBB);
    check("t4_ready_after", 32'(src0_ready), 32'(BYPASS));
    check("t4_data_after", src0_data, BYPASS ? 32'hBB : 32'h0);
    step();

    // Store and x0 destinations.
    do_reset();
    src0_addr = 5'd0;
    alloc(1'b0, 5'd4);
    check("store_commit_wen", 32'(commit_wen), 32'd0);
    step();
    alloc(1'b1, 5'd0);
    check("x0_pending", 32'(src0_pending), 32'd0);
    fill(0, 1, 32'hDEAD);
    step();

    // Reset mid-operation, late fill ignored.
    do_reset();
    repeat (5) alloc(1'b1, 5'd6);
    src0_addr = 5'd6;
    idle(); reset = 1'b1; step(); idle();
    check("rst_pending", 32'(src0_pending), 32'd0);
    fill(0, 2, 32'h77);
    step();

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      reset       = ($urandom_range(0, 299) == 0);
      alloc_val   = ($urandom_range(0, 9) < 6);
      alloc_wen   = ($urandom_range(0, 3) != 0);
      alloc_waddr = 5'($urandom_range(0, 7));
      src0_addr   = 5'($urandom_range(0, 7));
      src1_addr   = 5'($urandom_range(0, 7));
      cand.delete();
      foreach (order[k]) if (!m_done[order[k]]) cand.push_back(order[k]);
      fill0_val  = ($urandom_range(0, 2) != 0);
      fill0_tag  = (cand.size() > 0 && $urandom_range(0, 7) != 0) ?
                   4'(cand[$urandom_range(0, cand.size() - 1)]) : 4'($urandom_range(0, N - 1));
      fill0_data = $urandom;
      fill1_val  = ($urandom_range(0, 2) != 0);
      fill1_tag  = (cand.size() > 0 && $urandom_range(0, 7) != 0) ?
                   4'(cand[$urandom_range(0, cand.size() - 1)]) : 4'($urandom_range(0, N - 1));
      fill1_data = $urandom;
      if (fill0_val && fill1_val && fill0_tag == fill1_tag) fill1_val = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
